// File: rtl/uart_xmt_if.sv
// Byte-load handshake between the command/response byte source and the serial transmitter.
interface uart_xmt_if;
  logic       load;
  logic [7:0] parallel_in;
  logic       ready;
  logic       busy;

  modport master (output load, output parallel_in, input ready, input busy);
  modport slave  (input load, input parallel_in, output ready, output busy);
endinterface

// File: rtl/uart_xmt.sv
// 8N1 serial transmitter, LSB first, idle-high, registered line output.
// Define UART_XMT_HOLD_EN to add a one-byte holding register for gap-free back-to-back frames.
module uart_xmt #(
  parameter int unsigned CLKS_PER_BIT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  uart_xmt_if.slave  bus,
  output logic       serial_out
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] RELOAD = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic        start_go;
  logic [7:0]  start_byte;
`ifdef UART_XMT_HOLD_EN
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    serial_d = serial_q;
    accept   = bus.load && ready_q;
`ifdef UART_XMT_HOLD_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    // A byte accepted mid-frame (or on the final stop edge) parks in hold.
    if (accept && state_q != IDLE) begin
      hold_d      = bus.parallel_in;
      hold_full_d = 1'b1;
    end
    start_go   = hold_full_q || accept;
    start_byte = hold_full_q ? hold_q : bus.parallel_in;
`else
    start_go   = accept;
    start_byte = bus.parallel_in;
`endif

    case (state_q)
      IDLE: begin
        if (start_go) begin
          shift_d  = start_byte;
          cnt_d    = RELOAD;
          serial_d = 1'b0;
          state_d  = START;
`ifdef UART_XMT_HOLD_EN
          if (hold_full_q) hold_full_d = 1'b0;
`endif
        end
      end
      START: begin
        if (cnt_q == 16'd0) begin
          cnt_d    = RELOAD;
          serial_d = shift_q[0];
          idx_d    = 3'd0;
          state_d  = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = RELOAD;
          if (idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            serial_d = shift_q[1];
            idx_d    = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = RELOAD;
          state_d = IDLE;
`ifdef UART_XMT_HOLD_EN
          // Chain the held byte straight into a new start bit, no idle gap.
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            serial_d    = 1'b0;
            state_d     = START;
          end
`endif
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
`ifdef UART_XMT_HOLD_EN
    ready_d = !hold_full_d;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'd0;
      serial_q    <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_XMT_HOLD_EN
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      serial_q    <= serial_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef UART_XMT_HOLD_EN
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
`endif
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign serial_out = serial_q;

endmodule

// File: tb/tb_uart_xmt.sv
// Randomised self-checking bench for uart_xmt: a queue of expected line samples is the reference.
module tb_uart_xmt;
  localparam int CPB = 16;
`ifdef UART_XMT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic serial_out;

  uart_xmt_if bus ();

  uart_xmt #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: every accepted byte becomes 10*CPB expected line samples.
  bit         line_q[$];
  logic [7:0] hold_byte = 8'd0;
  bit         hold_full = 1'b0;
  bit         exp_ser   = 1'b1;
  bit         exp_busy  = 1'b0;
  bit         exp_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) line_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) line_q.push_back(b[k]);
    for (int i = 0; i < CPB; i++) line_q.push_back(1'b1);
  endfunction

  // One clock: drive inputs, advance the model across the edge, compare outputs.
  task automatic step(input logic rst_n, input logic ld, input logic [7:0] d);
    bit acc;
    reset           = rst_n;
    bus.load        = ld;
    bus.parallel_in = d;
    @(posedge clk);
    acc = rst_n && ld && exp_ready;
    if (!rst_n) begin
      line_q.delete();
      hold_full = 1'b0;
    end else begin
      if (HOLD && line_q.size() == 0 && hold_full) begin
        push_frame(hold_byte);
        hold_full = 1'b0;
      end
      if (acc) begin
        if (!exp_busy) push_frame(d);
        else begin
          hold_byte = d;
          hold_full = 1'b1;
        end
      end
    end
    if (line_q.size() > 0) begin
      exp_ser  = line_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_ser  = 1'b1;
      exp_busy = 1'b0;
    end
    exp_ready = HOLD ? !hold_full : !exp_busy;
    #1;
    chk("serial_out", {31'd0, serial_out}, {31'd0, exp_ser});
    chk("busy",       {31'd0, bus.busy},   {31'd0, exp_busy});
    chk("ready",      {31'd0, bus.ready},  {31'd0, exp_ready});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    bus.load        = 1'b0;
    bus.parallel_in = 8'h00;

    // Reset state
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    idle_cycles(3);

    // Single frame 0xA5 from idle, with an ignored 0x99 load mid-frame
    step(1'b1, 1'b1, 8'hA5);
    idle_cycles(40);
    step(1'b1, 1'b1, 8'h99);
    idle_cycles(140);

    // Load held high: 0x3C until accepted, then 0xC3
    begin
      bit first_taken = 1'b0;
      for (int i = 0; i < 360; i++) begin
        if (!first_taken && exp_ready) begin
          step(1'b1, 1'b1, 8'h3C);
          first_taken = 1'b1;
        end else begin
          step(1'b1, 1'b1, 8'hC3);
        end
      end
    end
    step(1'b1, 1'b0, 8'h00);
    idle_cycles(170);

    // Two loads inside one frame, then 0x99 while ready is low
    step(1'b1, 1'b1, 8'h11);
    idle_cycles(20);
    step(1'b1, 1'b1, 8'h22);
    idle_cycles(20);
    step(1'b1, 1'b1, 8'h99);
    idle_cycles(340);

    // Reset during DATA bit 3 of 0x0F, then 200 quiet cycles
    step(1'b1, 1'b1, 8'h0F);
    idle_cycles(CPB + 3 * CPB + 4);
    step(1'b0, 1'b0, 8'h00);
    idle_cycles(200);

    // Randomised traffic with rare resets
    for (int i = 0; i < 5000; i++) begin
      logic ld;
      logic rn;
      logic [7:0] d;
      ld = ($urandom_range(0, 24) == 0);
      rn = ($urandom_range(0, 2499) != 0);
      d  = 8'($urandom);
      step(rn, ld, d);
    end
    idle_cycles(2 * 10 * CPB + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_xmt.md
Name: uart_xmt

Overview:
- Serial transmitter, the partner of the existing serial receiver: 8 data bits, no parity, 1 stop bit, LSB first, idle line high.
- Default bit period is 50000 clk cycles, matching the receiver's timing.
- Sits in the GPU serial subsystem between the command/response logic (byte source) and the off-chip serial line.
- Provides a one-byte load handshake and a registered, glitch-free serial output.

Parameters:
- CLKS_PER_BIT, 50000: clk cycles per bit on the line. Legal range 2..65535; the bit counter is 16 bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
- load  input  1  byte-valid strobe; sampled on rising clk.
- parallel_in  input  8  byte to send; sampled only on an accepting edge.
- ready  output  1  block can accept a byte this cycle.
- busy  output  1  a frame is on the line (START, DATA or STOP).
- serial_out  output  1  serial line, registered.

Behaviour:
- States: IDLE, START, DATA, STOP. Registers:
  - 16-bit down-counter cnt.
  - 3-bit bit index idx.
  - 8-bit shift register.
- Reset (reset==0 at an edge), after that edge:
  - state=IDLE, serial_out=1, ready=1, busy=0.
  - Holding register empty; cnt and idx cleared.
  - Applies mid-frame too: the frame is abandoned and the line returns high immediately. No partial-frame completion.
- Accept: an edge with load==1 && ready==1 accepts the byte.
  - load while ready==0 is ignored, with no side effects.
  - parallel_in is don't-care on all non-accepting edges.
- IDLE, accept: shift<=parallel_in, cnt<=CLKS_PER_BIT-1, state<=START. serial_out goes 0 on the same edge, so the start bit begins the cycle after the load cycle.
- START/DATA/STOP: each bit is held exactly CLKS_PER_BIT cycles. cnt decrements each cycle; a bit ends on the cycle where cnt==0, which also reloads cnt to CLKS_PER_BIT-1.
- START end: serial_out<=shift[0], idx<=0, state<=DATA.
- DATA end:
  - If idx==7: serial_out<=1, state<=STOP.
  - Otherwise: shift right by one, serial_out<=next bit, idx<=idx+1.
- STOP end: state<=IDLE, serial_out stays 1.
- Frame length: exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Outputs:
  - busy=1 exactly while state is START, DATA or STOP.
  - ready=1 in IDLE and 0 otherwise, in the base build.
  - Back-to-back loads in the base build: at least one idle-high cycle between a stop bit and the next start bit.
- serial_out changes only on bit boundaries. It is never X after reset.

Optional Feature:
- Macro: UART_XMT_HOLD_EN.
- Without it: single buffer, behaviour as above.
- With it: a one-byte holding register (hold, hold_full). ready = !hold_full.
  - Accept in IDLE with hold empty: the byte goes directly to the shifter as in the base build; ready stays 1.
  - Accept during START/DATA/STOP: hold<=parallel_in, hold_full<=1, ready drops the next cycle.
  - At STOP end with hold_full: shift<=hold, hold_full<=0, state<=START, serial_out<=0. The next start bit immediately follows the last stop cycle with no idle gap. ready rises the cycle after.
  - At STOP end with hold empty: go to IDLE as in the base build.
  - Simultaneous load and STOP end with hold empty: the byte is treated as an IDLE accept, so the start bit follows with one idle-high cycle.
  - Reset also empties hold.

Test Plan:
- CLKS_PER_BIT=16, load 0xA5 from IDLE -> serial_out: 0 for cycles 1-16, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then stop 1 for 16 cycles. busy=1 for exactly 160 cycles; ready returns to 1 the cycle after the stop bit ends.
- Loopback with the existing receiver, default CLKS_PER_BIT=50000, bytes 0x00, 0xFF, 0x55, 0x80 -> receiver full pulses once per byte with parallel_out equal to each sent byte.
- Base build, load held high continuously with 0x3C then 0xC3 -> two complete frames separated by exactly one idle-high cycle; the second byte is accepted only while ready==1.
- reset driven low during DATA bit 3 of 0x0F -> next edge: serial_out=1, busy=0, ready=1. Stays high for the following 200 cycles with no further transitions.
- UART_XMT_HOLD_EN, CLKS_PER_BIT=8, load 0x11 then 0x22 during the first frame -> ready=0 after the second load; second start bit directly follows the first stop bit (cycle 81); 160 contiguous frame cycles total.
- load asserted while busy with ready==0 (either build), byte 0x99 -> ignored; the current frame is unchanged and 0x99 is never transmitted.
